logic_unit_seq: RTL and testbench

LOGIC_UNIT_SEQ -- requirements
Module: logic_unit_seq

---
 rtl/logic_unit_pkg.sv | 51 +++++
 rtl/logic_op_eval.sv | 27 ++
 rtl/logic_unit_seq.sv | 207 ++++++++++++++++++++
 tb/tb_logic_unit_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// ---------------------------------------------------------------------------
// logic_unit_pkg
//   Shared definitions for the logic_unit_seq block:
//     op_e      - 3-bit operation codes (bitwise logic functions)
//     state_e   - sequencer states (IDLE / HOLD / GAP)
//     OP_LAST   - last op code of an auto-mode sweep
//     GAP_CNT_W - width of the inter-result dwell counter
//     eval_bit  - single-bit evaluation of an op; the word evaluator
//                 replicates it across the operand width
// ---------------------------------------------------------------------------
package logic_unit_pkg;

  typedef enum logic [2:0] {
    OP_NOT_A = 3'd0,  // ~a
    OP_A     = 3'd1,  //  a
    OP_XNOR  = 3'd2,  // ~(a ^ b)
    OP_XOR   = 3'd3,  //  a ^ b
    OP_OR    = 3'd4,  //  a | b
    OP_NOR   = 3'd5,  // ~(a | b)
    OP_AND   = 3'd6,  //  a & b
    OP_NAND  = 3'd7   // ~(a & b)
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for a request, in_ready high
    ST_HOLD = 2'd1,  // result presented, waiting for out_ready
    ST_GAP  = 2'd2   // auto-mode dwell between results
  } state_e;

  localparam logic [2:0] OP_FIRST  = 3'd0;
  localparam logic [2:0] OP_LAST   = 3'd7;
  localparam int         GAP_CNT_W = 8;

  // Every op is purely bitwise, so one bit slice fully describes it.
  function automatic logic eval_bit(input op_e op, input logic a, input logic b);
    logic r;
    case (op)
      OP_NOT_A: r = ~a;
      OP_A:     r = a;
      OP_XNOR:  r = ~(a ^ b);
      OP_XOR:   r = a ^ b;
      OP_OR:    r = a | b;
      OP_NOR:   r = ~(a | b);
      OP_AND:   r = a & b;
      OP_NAND:  r = ~(a & b);
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_op_eval.sv
// ---------------------------------------------------------------------------
// logic_op_eval
//   Purely combinational WIDTH-bit logic evaluator.
//   Ports:
//     op [2:0]       - operation code (see logic_unit_pkg::op_e)
//     a, b [WIDTH-1:0] - operands
//     y  [WIDTH-1:0] - result, y = f(op, a, b)
// ---------------------------------------------------------------------------
module logic_op_eval
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  op_e op_sel;
  assign op_sel = op_e'(op);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign y[gi] = eval_bit(op_sel, a[gi], b[gi]);
  end

endmodule

// File: rtl/logic_unit_seq.sv
// ---------------------------------------------------------------------------
// logic_unit_seq
//   Sequenced bitwise logic unit. A request (a, b, op, auto_mode) is taken
//   on an in_valid/in_ready handshake. Manual mode produces one result
//   f(op,a,b); auto mode sweeps ops 0..7 over the latched operands, with
//   DWELL idle cycles between results. Each result is held until it is
//   taken on the out_valid/out_ready handshake; done pulses for one cycle
//   when the request retires, coinciding with in_ready returning high.
//   Parameters:
//     WIDTH - operand/result width (1..32)
//     DWELL - idle cycles between successive auto-mode results (0..255)
//   Ports:
//     clk, rst_n         - clock, asynchronous active-low reset
//     a, b               - operands
//     op                 - op select (manual mode)
//     auto_mode          - 0 single op, 1 sweep of all 8 ops
//     in_valid, in_ready - request handshake (in_ready high only in IDLE)
//     out_valid, out_ready - result handshake
//     out_data, out_op   - registered result and the op that produced it
//     done               - one-cycle retire pulse
// ---------------------------------------------------------------------------
module logic_unit_seq
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             auto_mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_op,
  output logic             done
);

  // The GAP state is left when the counter reads zero, so loading DWELL-1
  // yields exactly DWELL cycles with out_valid low.
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
    (DWELL > 0) ? GAP_CNT_W'(DWELL - 1) : '0;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e               state_q,     state_d;
  logic                 auto_q,      auto_d;
  logic [WIDTH-1:0]     a_lat_q,     a_lat_d;
  logic [WIDTH-1:0]     b_lat_q,     b_lat_d;
  logic [2:0]           cnt_q,       cnt_d;
  logic [GAP_CNT_W-1:0] gap_q,       gap_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q,  out_data_d;
  logic [2:0]           out_op_q,    out_op_d;
  logic                 done_q,      done_d;

  // -------------------------------------------------------------------------
  // Shared evaluator. Its inputs are steered to whatever result the next
  // edge may load: the incoming request in IDLE, the following sweep op in
  // HOLD (used when DWELL is 0), and the already-advanced op in GAP.
  // -------------------------------------------------------------------------
  logic [2:0]       eval_op;
  logic [WIDTH-1:0] eval_a;
  logic [WIDTH-1:0] eval_b;
  logic [WIDTH-1:0] eval_y;

  always_comb begin
    eval_op = cnt_q;
    eval_a  = a_lat_q;
    eval_b  = b_lat_q;
    case (state_q)
      ST_IDLE: begin
        eval_op = auto_mode ? OP_FIRST : op;
        eval_a  = a;
        eval_b  = b;
      end
      ST_HOLD: eval_op = cnt_q + 3'd1;
      default: eval_op = cnt_q;
    endcase
  end

  logic_op_eval #(
    .WIDTH (WIDTH)
  ) u_eval (
    .op (eval_op),
    .a  (eval_a),
    .b  (eval_b),
    .y  (eval_y)
  );

  // -------------------------------------------------------------------------
  // Sequencer next-state
  // -------------------------------------------------------------------------
  logic last_result;
  assign last_result = !auto_q || (cnt_q == OP_LAST);

  always_comb begin
    state_d     = state_q;
    auto_d      = auto_q;
    a_lat_d     = a_lat_q;
    b_lat_d     = b_lat_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_op_d    = out_op_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_lat_d     = a;
          b_lat_d     = b;
          auto_d      = auto_mode;
          cnt_d       = OP_FIRST;
          out_valid_d = 1'b1;
          out_data_d  = eval_y;
          out_op_d    = eval_op;
          state_d     = ST_HOLD;
        end
      end

      ST_HOLD: begin
        // out_valid is always high here, so out_ready alone is the handshake.
        if (out_ready) begin
          if (last_result) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            cnt_d       = OP_FIRST;
            state_d     = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
            if (DWELL == 0) begin
              out_data_d = eval_y;
              out_op_d   = eval_op;
            end else begin
              out_valid_d = 1'b0;
              gap_d       = GAP_LOAD;
              state_d     = ST_GAP;
            end
          end
        end
      end

      ST_GAP: begin
        if (gap_q == '0) begin
          out_valid_d = 1'b1;
          out_data_d  = eval_y;
          out_op_d    = cnt_q;
          state_d     = ST_HOLD;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        cnt_d       = OP_FIRST;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      auto_q      <= 1'b0;
      a_lat_q     <= '0;
      b_lat_q     <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_op_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      auto_q      <= auto_d;
      a_lat_q     <= a_lat_d;
      b_lat_q     <= b_lat_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_op_q    <= out_op_d;
      done_q      <= done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_op    = out_op_q;
  assign done      = done_q;

endmodule

// File: tb/tb_logic_unit_seq.sv
module tb_logic_unit_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Index 0: DWELL=0 instance, index 1: DWELL=4 instance.
  logic [W-1:0] a_s  [2];
  logic [W-1:0] b_s  [2];
  logic [2:0]   op_s [2];
  logic         am_s [2];
  logic         iv_s [2];
  logic         or_s [2];
  logic         ir_s [2];
  logic         ov_s [2];
  logic [W-1:0] od_s [2];
  logic [2:0]   oo_s [2];
  logic         dn_s [2];

  int total = 0;
  int bad   = 0;
  logic [W-1:0] obs_q[$];

  logic_unit_seq #(.WIDTH(W), .DWELL(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .a(a_s[0]), .b(b_s[0]), .op(op_s[0]),
    .auto_mode(am_s[0]), .in_valid(iv_s[0]), .in_ready(ir_s[0]),
    .out_valid(ov_s[0]), .out_ready(or_s[0]), .out_data(od_s[0]),
    .out_op(oo_s[0]), .done(dn_s[0])
  );

  logic_unit_seq #(.WIDTH(W), .DWELL(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .a(a_s[1]), .b(b_s[1]), .op(op_s[1]),
    .auto_mode(am_s[1]), .in_valid(iv_s[1]), .in_ready(ir_s[1]),
    .out_valid(ov_s[1]), .out_ready(or_s[1]), .out_data(od_s[1]),
    .out_op(oo_s[1]), .done(dn_s[1])
  );

  function automatic int dwell_of(input int k);
    return (k == 0) ? 0 : 4;
  endfunction

  // Word-level reference for the eight logic functions.
  function automatic logic [W-1:0] model(input int opc, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    case (opc)
      0: r = ~x;
      1: r = x;
      2: r = ~(x ^ y);
      3: r = x ^ y;
      4: r = x | y;
      5: r = ~(x | y);
      6: r = x & y;
      default: r = ~(x & y);
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request from acceptance to retirement, checking every cycle.
  // rmode: 0 out_ready always high, 1 random, 2 stall 10 cycles on op 5.
  // chain: leave in_valid high into the done cycle for back-to-back.
  task automatic run_req(input int k, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [2:0] opv, input logic am, input int rmode, input logic chain);
    int   exp_ops[$];
    int   gap_left = 0;
    int   stall = 0;
    int   cyc = 0;
    bit   fin = 0;
    logic r;
    check("idle_ready", 32'(ir_s[k]), 32'd1);
    a_s[k] = av; b_s[k] = bv; op_s[k] = opv; am_s[k] = am; iv_s[k] = 1'b1;
    or_s[k] = 1'($urandom);
    if (am) for (int i = 0; i < 8; i++) exp_ops.push_back(i);
    else exp_ops.push_back(int'(opv));
    obs_q.delete();
    step();
    while (!fin) begin
      a_s[k] = W'($urandom); b_s[k] = W'($urandom); op_s[k] = 3'($urandom);
      am_s[k] = 1'($urandom); iv_s[k] = 1'($urandom);
      check("busy_ready", 32'(ir_s[k]), 32'd0);
      check("busy_done", 32'(dn_s[k]), 32'd0);
      if (gap_left > 0) begin
        check("gap_valid", 32'(ov_s[k]), 32'd0);
        gap_left--;
        or_s[k] = 1'($urandom);
      end else begin
        check("res_valid", 32'(ov_s[k]), 32'd1);
        check("res_op", 32'(oo_s[k]), exp_ops[0]);
        check("res_data", 32'(od_s[k]), 32'(model(exp_ops[0], av, bv)));
        case (rmode)
          0: r = 1'b1;
          1: r = 1'($urandom);
          default: begin
            if (exp_ops[0] == 5 && stall < 10) begin r = 1'b0; stall++; end
            else r = 1'b1;
          end
        endcase
        or_s[k] = r;
        if (r) begin
          obs_q.push_back(od_s[k]);
          void'(exp_ops.pop_front());
          if (exp_ops.size() == 0) begin
            fin = 1;
            iv_s[k] = chain;
          end else begin
            gap_left = dwell_of(k);
          end
        end
      end
      cyc++;
      if (cyc > 1000) begin
        check("timeout", 32'd0, 32'd1);
        fin = 1;
        iv_s[k] = 1'b0;
      end
      step();
    end
    or_s[k] = 1'($urandom);
    check("done_pulse", 32'(dn_s[k]), 32'd1);
    check("done_ready", 32'(ir_s[k]), 32'd1);
    check("done_valid", 32'(ov_s[k]), 32'd0);
    $display("req k=%0d a=%0h b=%0h op=%0d auto=%0d results=%0d", k, av, bv, opv, am, obs_q.size());
  endtask

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      iv_s[k] = 1'b0;
      or_s[k] = 1'($urandom);
      step();
      check("idle_done", 32'(dn_s[k]), 32'd0);
      check("idle_valid", 32'(ov_s[k]), 32'd0);
      check("idle_ready", 32'(ir_s[k]), 32'd1);
    end
  endtask

  logic [W-1:0] sweep_tbl [8];
  int           lim;
  logic         ch;

  initial begin
    for (int k = 0; k < 2; k++) begin
      a_s[k] = '0; b_s[k] = '0; op_s[k] = '0; am_s[k] = 1'b0; iv_s[k] = 1'b0; or_s[k] = 1'b0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_valid", 32'(ov_s[k]), 32'd0);
      check("rst_data", 32'(od_s[k]), 32'd0);
      check("rst_op", 32'(oo_s[k]), 32'd0);
      check("rst_done", 32'(dn_s[k]), 32'd0);
      check("rst_ready", 32'(ir_s[k]), 32'd1);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Manual op 3 on the first edge after reset release.
    run_req(0, 8'hF0, 8'hCC, 3'd3, 1'b0, 0, 1'b0);
    check("manual_3C", 32'(obs_q[0]), 32'h3C);
    idle(0, 2);

    // Full sweep, no dwell, against the literal result table.
    sweep_tbl[0] = 8'h0F; sweep_tbl[1] = 8'hF0; sweep_tbl[2] = 8'hC3; sweep_tbl[3] = 8'h3C;
    sweep_tbl[4] = 8'hFC; sweep_tbl[5] = 8'h03; sweep_tbl[6] = 8'hC0; sweep_tbl[7] = 8'h3F;
    run_req(0, 8'hF0, 8'hCC, 3'd6, 1'b1, 0, 1'b0);
    check("sweep_count", obs_q.size(), 32'd8);
    for (int i = 0; i < 8 && i < obs_q.size(); i++) check("sweep_tbl", 32'(obs_q[i]), 32'(sweep_tbl[i]));
    idle(0, 1);

    // Dwell sweep and backpressure on op 5.
    run_req(1, 8'hF0, 8'hCC, 3'd0, 1'b1, 0, 1'b0);
    idle(1, 1);
    run_req(1, W'($urandom), W'($urandom), 3'd2, 1'b1, 2, 1'b0);
    idle(1, 1);
    run_req(0, W'($urandom), W'($urandom), 3'd2, 1'b1, 2, 1'b0);
    idle(0, 1);

    // Back-to-back across done.
    run_req(0, 8'h5A, 8'h33, 3'd7, 1'b0, 0, 1'b1);
    run_req(0, 8'hA5, 8'h0F, 3'd4, 1'b0, 0, 1'b0);
    idle(0, 1);

    // Randomized requests on both instances.
    for (int i = 0; i < 24; i++) begin
      ch = (i % 6 == 5) ? 1'b0 : 1'($urandom);
      run_req(i % 2 == 0 ? 0 : 1, W'($urandom), W'($urandom), 3'($urandom),
              1'($urandom_range(0, 2) == 0), 1, ch);
      if (!ch) idle(i % 2 == 0 ? 0 : 1, 1);
      else begin
        run_req(i % 2 == 0 ? 0 : 1, W'($urandom), W'($urandom), 3'($urandom), 1'b0, 1, 1'b0);
        idle(i % 2 == 0 ? 0 : 1, 1);
      end
    end

    // Reset in the middle of a dwell sweep at result 3.
    a_s[1] = 8'hF0; b_s[1] = 8'hCC; am_s[1] = 1'b1; iv_s[1] = 1'b1; or_s[1] = 1'b1;
    step();
    iv_s[1] = 1'b0;
    lim = 0;
    while (!(ov_s[1] && oo_s[1] == 3'd3) && lim < 200) begin
      step();
      lim++;
    end
    check("rst_reach3", 32'(lim < 200), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(ov_s[1]), 32'd0);
    check("mid_rst_data", 32'(od_s[1]), 32'd0);
    check("mid_rst_op", 32'(oo_s[1]), 32'd0);
    check("mid_rst_done", 32'(dn_s[1]), 32'd0);
    check("mid_rst_ready", 32'(ir_s[1]), 32'd1);
    $display("reset asserted mid-sweep at op 3");
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    idle(1, 3);
    run_req(1, 8'h96, 8'h69, 3'd5, 1'b0, 0, 1'b0);
    idle(1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
